// File: rtl/tester_pkg.sv
// Shared definitions for the UART transmit arbiter.
package tester_pkg;

  localparam int unsigned N_REQ_DEF = 3;
  localparam int unsigned GRANT_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_SEND
  } state_t;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Round-robin selector: first set request after last_grant, wrapping modulo N_REQ.
module rr_pick
  import tester_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] sel,
  output logic               valid
);

  // Scan offsets 1..N_REQ from last; the first requesting index wins.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!valid && req[j] && (j == (32'(last) + off) % N_REQ)) begin
          valid = 1'b1;
          sel   = GRANT_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates several byte requesters onto a single uart_tx, with a service timeout.
module tx_arbiter
  import tester_pkg::*;
#(
  parameter int unsigned N_REQ       = N_REQ_DEF,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic [N_REQ-1:0]   in_req,
  input  logic [N_REQ*8-1:0] in_data,
  input  logic               in_utx_s_bs,
  input  logic               in_utx_s_rd,
  output logic [N_REQ-1:0]   out_ack,
  output logic [1:0]         out_grant,
  output logic [7:0]         out_utx_data,
  output logic               out_utx_s_en,
  output logic               out_busy,
  output logic               out_err
);

  localparam int unsigned       CNT_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]        LAST_RST  = 2'(N_REQ - 1);

  state_t             state;
  logic [1:0]         last_grant;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         pick;
  logic               pick_vld;
  logic [7:0]         pick_data;
  logic [N_REQ-1:0]   pick_hot;
  logic               timeout;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (in_req),
    .last  (last_grant),
    .sel   (pick),
    .valid (pick_vld)
  );

  // Byte and one-hot ack for the requester the selector currently points at.
  always_comb begin
    pick_data = '0;
    pick_hot  = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (pick == 2'(j)) begin
        pick_data   = in_data[j*8 +: 8];
        pick_hot[j] = 1'b1;
      end
    end
  end

  assign timeout = (cnt == CNT_LAST);

  // Service FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state        <= ST_IDLE;
      out_ack      <= '0;
      out_utx_s_en <= 1'b0;
      out_busy     <= 1'b0;
      out_err      <= 1'b0;
      out_grant    <= '0;
      out_utx_data <= '0;
      cnt          <= '0;
      last_grant   <= LAST_RST;
    end else begin
      out_err <= 1'b0;
      out_ack <= '0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pick_vld) begin
            out_grant    <= pick;
            out_utx_data <= pick_data;
            out_ack      <= pick_hot;
            out_busy     <= 1'b1;
            state        <= ST_LOAD;
          end
        end
        default: begin
          // Timeout is checked before the per-state moves so it overrides a same-cycle rd.
          if (timeout) begin
            state        <= ST_IDLE;
            out_busy     <= 1'b0;
            out_utx_s_en <= 1'b0;
            out_err      <= 1'b1;
            last_grant   <= out_grant;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            case (state)
              ST_LOAD: state <= ST_WAIT;
              ST_WAIT: begin
                if (!in_utx_s_bs) begin
                  state        <= ST_SEND;
                  out_utx_s_en <= 1'b1;
                end
              end
              ST_SEND: begin
                if (in_utx_s_rd) begin
                  state        <= ST_IDLE;
                  out_utx_s_en <= 1'b0;
                  out_busy     <= 1'b0;
                  last_grant   <= out_grant;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter against a transaction-timeline reference model.
module tb_tx_arbiter;

  localparam int N = 3;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         in_rst;
  logic [N-1:0] in_req;
  logic [N*8-1:0] in_data;
  logic         in_utx_s_bs;
  logic         in_utx_s_rd;
  logic [N-1:0] out_ack;
  logic [1:0]   out_grant;
  logic [7:0]   out_utx_data;
  logic         out_utx_s_en;
  logic         out_busy;
  logic         out_err;

  int nchk = 0;
  int nbad = 0;
  int last_m;

  tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
    .in_clk       (clk),
    .in_rst       (in_rst),
    .in_req       (in_req),
    .in_data      (in_data),
    .in_utx_s_bs  (in_utx_s_bs),
    .in_utx_s_rd  (in_utx_s_rd),
    .out_ack      (out_ack),
    .out_grant    (out_grant),
    .out_utx_data (out_utx_data),
    .out_utx_s_en (out_utx_s_en),
    .out_busy     (out_busy),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_rst = 1'b0; in_req = '0; in_data = '0; in_utx_s_bs = 1'b0; in_utx_s_rd = 1'b0;
    step();
    step();
    check("rst_busy", 32'(out_busy), 0);
    check("rst_ack",  32'(out_ack), 0);
    check("rst_en",   32'(out_utx_s_en), 0);
    check("rst_err",  32'(out_err), 0);
    check("rst_grant", 32'(out_grant), 0);
    check("rst_data", 32'(out_utx_data), 0);
    in_rst = 1'b1;
    last_m = N - 1;
  endtask

  // Idle cycles with optional stray rd pulses; nothing may happen.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_busy", 32'(out_busy), 0);
      check("idle_ack",  32'(out_ack), 0);
      check("idle_en",   32'(out_utx_s_en), 0);
      in_req = '0;
      in_utx_s_bs = 1'($urandom_range(0, 1));
      in_utx_s_rd = 1'($urandom_range(0, 1));
    end
  endtask

  // One service. Cycle 0 is the IDLE decision cycle; the uart is busy for b
  // WAIT cycles; rd arrives r cycles after send enable first rises.
  // abort_k != 0 pulls reset during relative cycle abort_k.
  task automatic txn(input logic [N-1:0] vec, input logic [N*8-1:0] dv,
                     input int b, input int r, input bit stray, input int abort_k);
    int sel;
    int endk;
    bit to;
    logic [7:0] exp_byte;
    logic [N-1:0] exp_ack;
    bit exp_en;
    sel = -1;
    for (int i = 1; i <= N; i++) begin
      int j;
      j = (last_m + i) % N;
      if (sel < 0 && vec[j]) sel = j;
    end
    to = (3 + b + r >= T);
    endk = to ? T : 3 + b + r;
    exp_byte = dv[sel*8 +: 8];

    step();
    check("d0_busy", 32'(out_busy), 0);
    in_req = vec; in_data = dv; in_utx_s_bs = 1'b0; in_utx_s_rd = stray;

    for (int k = 1; k <= endk + 1; k++) begin
      step();
      if (abort_k != 0 && k == abort_k + 1) begin
        check("ab_busy",  32'(out_busy), 0);
        check("ab_ack",   32'(out_ack), 0);
        check("ab_en",    32'(out_utx_s_en), 0);
        check("ab_err",   32'(out_err), 0);
        check("ab_grant", 32'(out_grant), 0);
        check("ab_data",  32'(out_utx_data), 0);
        in_rst = 1'b1; in_req = '0; in_utx_s_bs = 1'b0; in_utx_s_rd = 1'b0;
        last_m = N - 1;
        return;
      end
      exp_ack = (k == 1) ? N'(1 << sel) : '0;
      exp_en  = (k >= 3 + b) && (k <= endk);
      check("ack",  32'(out_ack), 32'(exp_ack));
      check("en",   32'(out_utx_s_en), 32'(exp_en));
      check("busy", 32'(out_busy), 32'(k <= endk));
      check("err",  32'(out_err), 32'(to && (k == endk + 1)));
      if (k == 1) begin
        check("grant", 32'(out_grant), 32'(sel));
        check("data",  32'(out_utx_data), 32'(exp_byte));
      end
      if (exp_en) check("data_en", 32'(out_utx_data), 32'(exp_byte));
      if (k == 1) begin
        in_req = '0;
        in_data = N*8'($urandom);
      end
      in_utx_s_bs = (k >= 2) && (k < 2 + b);
      in_utx_s_rd = (k == 3 + b + r) || (stray && k == 2);
      if (abort_k != 0 && k == abort_k) in_rst = 1'b0;
    end
    last_m = sel;
    in_utx_s_rd = 1'b0;
  endtask

  initial begin
    logic [N-1:0] v;
    do_reset();

    // fairness: all requesting, expected order 0,1,2,0,1,2
    for (int i = 0; i < 6; i++) txn('1, N*8'($urandom), 0, $urandom_range(0, 3), 1'b0, 0);
    idle(2);

    // single requester 1 with 0xA5
    txn(3'b010, 24'h00A500, 0, 4, 1'b0, 0);
    idle(1);

    // uart busy for 10 cycles
    txn(3'b101, N*8'($urandom), 10, 2, 1'b0, 0);
    // stray rd in IDLE decision and WAIT
    txn(3'b011, N*8'($urandom), 3, 1, 1'b1, 0);
    idle(1);

    // timeout: rd never in time, then rotation continues
    txn(3'b111, N*8'($urandom), 0, 30, 1'b0, 0);
    txn(3'b111, N*8'($urandom), 0, 0, 1'b0, 0);
    // timeout with rd on the same cycle
    txn(3'b110, N*8'($urandom), 2, T - 5, 1'b0, 0);

    // reset during SEND, then requester 0 wins
    txn(3'b111, N*8'($urandom), 0, 6, 1'b0, 5);
    txn(3'b101, N*8'($urandom), 0, 1, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      txn(v, N*8'($urandom), $urandom_range(0, 14), $urandom_range(0, 16),
          1'($urandom_range(0, 1)), 0);
      idle($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
